// File: rtl/ysyx_25040109_imem_pkg.sv
// rtl/ysyx_25040109_imem_pkg.sv - shared types and constants for the imem responder
package ysyx_25040109_imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ysyx_25040109_lfsr8.sv
// rtl/ysyx_25040109_lfsr8.sv - 8-bit Fibonacci LFSR advanced on demand
module ysyx_25040109_lfsr8
  import ysyx_25040109_imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/ysyx_25040109_imem_resp.sv
// rtl/ysyx_25040109_imem_resp.sv - instruction-memory responder with programmable latency
// IMEM_RAND_DELAY_EN replaces the fixed LATENCY with a per-request 1..8 cycle LFSR delay.
module ysyx_25040109_imem_resp
  import ysyx_25040109_imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imem_valid,
  output logic                     imem_ready,
  input  logic [31:0]              imem_addr,
  output logic [31:0]              imem_rdata,
  output logic                     imem_rdata_valid,
  input  logic                     imem_rdata_ready,
  output logic                     imem_err,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  imem_state_e state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic [31:0]   off;
  logic          fault;
  logic [AW-1:0] word_idx;
  logic          direct_resp;
  logic [3:0]    first_wait;

  assign accept   = imem_valid && (state == IDLE);
  assign off      = imem_addr - BASE_ADDR;
  assign fault    = (off >= SPAN) || (imem_addr[1:0] != 2'b00);
  assign word_idx = off[AW+1:2];

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  ysyx_25040109_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (accept),
    .q    (lfsr_q)
  );

  // latency is 1+lfsr[2:0]; the WAIT preload is latency-2
  assign direct_resp = (lfsr_q[2:0] == 3'd0);
  assign first_wait  = {1'b0, lfsr_q[2:0]} - 4'd1;
`else
  assign direct_resp = (LATENCY == 1);
  assign first_wait  = 4'(LATENCY - 2);
`endif

  assign imem_ready       = (state == IDLE);
  assign imem_rdata_valid = (state == RESP);
  assign imem_rdata       = rdata_q;
  assign imem_err         = err_q;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (imem_valid) begin
          if (direct_resp) begin
            state_next = RESP;
          end else begin
            cnt_next   = first_wait;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        if (imem_rdata_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // read happens before any same-edge backdoor write lands
      if (accept) begin
        err_q   <= fault;
        rdata_q <= fault ? IMEM_NOP : mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) mem[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_ysyx_25040109_imem_resp.sv
// tb/tb_ysyx_25040109_imem_resp.sv - randomized bench for the imem responder at latencies 1, 4 and 8
module tb_ysyx_25040109_imem_resp;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_we = 1'b0;
  logic [11:0] load_idx = '0;
  logic [31:0] load_data = '0;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] resp_data  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DEPTH];
  logic [7:0]  lfsr_m [3];

  always #5 clk = ~clk;

  ysyx_25040109_imem_resp #(.LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .imem_valid(req_valid[0]), .imem_ready(req_ready[0]), .imem_addr(req_addr[0]),
    .imem_rdata(resp_data[0]), .imem_rdata_valid(resp_valid[0]),
    .imem_rdata_ready(resp_ready[0]), .imem_err(resp_err[0]),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  ysyx_25040109_imem_resp #(.LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .imem_valid(req_valid[1]), .imem_ready(req_ready[1]), .imem_addr(req_addr[1]),
    .imem_rdata(resp_data[1]), .imem_rdata_valid(resp_valid[1]),
    .imem_rdata_ready(resp_ready[1]), .imem_err(resp_err[1]),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  ysyx_25040109_imem_resp #(.LATENCY(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .imem_valid(req_valid[2]), .imem_ready(req_ready[2]), .imem_addr(req_addr[2]),
    .imem_rdata(resp_data[2]), .imem_rdata_valid(resp_valid[2]),
    .imem_rdata_ready(resp_ready[2]), .imem_err(resp_err[2]),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output logic err);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'(DEPTH * 4) || a[1:0] != 2'b00) begin
      err = 1'b1;
      return NOP;
    end
    err = 1'b0;
    return mm[off[13:2]];
  endfunction

  // Expected latency of instance i's next request; consumes one LFSR step when random delay is on.
  function automatic int next_latency(input int i);
`ifdef IMEM_RAND_DELAY_EN
    int l;
    l = 1 + int'(lfsr_m[i][2:0]);
    lfsr_m[i] = {lfsr_m[i][6:0], lfsr_m[i][7] ^ lfsr_m[i][5] ^ lfsr_m[i][4] ^ lfsr_m[i][3]};
    return l;
`else
    return lat_of(i);
`endif
  endfunction

  task automatic fetch(input int i, input logic [31:0] a, input int hold,
                       input bit wr, input logic [11:0] widx, input logic [31:0] wdata);
    logic [31:0] exp_d, held_d;
    logic        exp_e, held_e;
    int          exp_lat, n;
    bit          leak, stable;
    @(negedge clk);
    check($sformatf("ready_idle[%0d]", i), 32'(req_ready[i]), 32'd1);
    req_valid[i]  = 1'b1;
    req_addr[i]   = a;
    resp_ready[i] = (hold == 0);
    if (wr) begin
      load_we = 1'b1; load_idx = widx; load_data = wdata;
    end
    exp_d   = model_read(a, exp_e);
    exp_lat = next_latency(i);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = $urandom;
    load_we      = 1'b0;
    if (wr) mm[widx] = wdata;
    n = 0;
    leak = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!resp_valid[i] && req_ready[i]) leak = 1'b1;
    end while (!resp_valid[i] && n < 40);
    check($sformatf("ready_busy[%0d]", i), 32'(leak), 32'd0);
    check($sformatf("latency[%0d] addr %h", i, a), 32'(n), 32'(exp_lat));
    check($sformatf("rdata[%0d] addr %h", i, a), resp_data[i], exp_d);
    check($sformatf("err[%0d] addr %h", i, a), 32'(resp_err[i]), 32'(exp_e));
    held_d = resp_data[i];
    held_e = resp_err[i];
    stable = 1'b1;
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      if (!resp_valid[i] || resp_data[i] !== held_d || resp_err[i] !== held_e || req_ready[i])
        stable = 1'b0;
    end
    if (hold > 0) check($sformatf("resp_stable[%0d]", i), 32'(stable), 32'd1);
    resp_ready[i] = 1'b1;
    @(negedge clk);
    check($sformatf("valid_drop[%0d]", i), 32'(resp_valid[i]), 32'd0);
    check($sformatf("ready_back[%0d]", i), 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b1;
      lfsr_m[i] = 8'hA5;
    end
    repeat (2) @(posedge clk);

    // backdoor preload runs while reset is held
    for (int w = 0; w < DEPTH; w++) begin
      @(negedge clk);
      load_we   = 1'b1;
      load_idx  = 12'(w);
      load_data = (w == 0) ? 32'h0010_0093 : (w == 1) ? 32'hDEAD_BEEF :
                  (w == 2) ? 32'h2222_2222 : $urandom;
      mm[w] = load_data;
    end
    @(negedge clk);
    load_we = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("rst_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
      check($sformatf("rst_rdata[%0d]", i), resp_data[i], 32'h0);
      check($sformatf("rst_err[%0d]", i), 32'(resp_err[i]), 32'd0);
    end

    fetch(0, 32'h8000_0000, 0, 1'b0, '0, '0);
    fetch(1, 32'h8000_0004, 0, 1'b0, '0, '0);
    fetch(1, 32'h8000_0004, 5, 1'b0, '0, '0);
    fetch(0, 32'h7FFF_FFFC, 0, 1'b0, '0, '0);
    fetch(0, 32'h8000_4000, 0, 1'b0, '0, '0);
    fetch(0, 32'h8000_0002, 0, 1'b0, '0, '0);
    fetch(0, 32'h8000_3FFC, 0, 1'b0, '0, '0);
    fetch(0, 32'h8000_0008, 0, 1'b1, 12'd2, 32'h1111_1111);
    fetch(0, 32'h8000_0008, 0, 1'b0, '0, '0);

    // reset while instance 2 is still waiting
    @(negedge clk);
    req_valid[2] = 1'b1; req_addr[2] = BASE; resp_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("busy_before_rst", 32'(req_ready[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) lfsr_m[i] = 8'hA5;
    @(negedge clk);
    check("abort_valid", 32'(resp_valid[2]), 32'd0);
    check("abort_ready", 32'(req_ready[2]), 32'd1);
    check("abort_rdata", resp_data[2], 32'h0);
    check("abort_err", 32'(resp_err[2]), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    check("no_resp_after_rst", 32'(seen), 32'd0);
    fetch(2, 32'h8000_0004, 0, 1'b0, '0, '0);

    for (int t = 0; t < 60; t++) begin
      int          i, r;
      logic [31:0] a;
      i = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      else if (r == 7) a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 8) a = $urandom;
      else             a = BASE - 32'(4 * $urandom_range(1, 100));
      fetch(i, a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
            12'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
